// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline-side hazard inputs and Freeze/Flush controls
interface hazard_stall_ctrl_if;
  logic       fwd_en;
  logic [4:0] Src1_ID;
  logic [4:0] Src2_ID;
  logic       two_src_ID;
  logic [4:0] Dst_EXE;
  logic       WB_EN_EXE;
  logic [1:0] MEM_CMD_EXE;
  logic [4:0] Dst_MEM;
  logic       WB_EN_MEM;
  logic [1:0] MEM_CMD_MEM;
  logic       cache_ready;
  logic       Br_taken;
  logic       Freeze_IF;
  logic       Flush_IF;
  logic       Flush_ID;
  logic       Freeze_pipe;
  modport master (
    output fwd_en, Src1_ID, Src2_ID, two_src_ID, Dst_EXE, WB_EN_EXE, MEM_CMD_EXE,
           Dst_MEM, WB_EN_MEM, MEM_CMD_MEM, cache_ready, Br_taken,
    input  Freeze_IF, Flush_IF, Flush_ID, Freeze_pipe
  );
  modport slave (
    input  fwd_en, Src1_ID, Src2_ID, two_src_ID, Dst_EXE, WB_EN_EXE, MEM_CMD_EXE,
           Dst_MEM, WB_EN_MEM, MEM_CMD_MEM, cache_ready, Br_taken,
    output Freeze_IF, Flush_IF, Flush_ID, Freeze_pipe
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: data/branch/cache-miss hazard detection driving pipeline freeze and flush
module hazard_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  hazard_stall_ctrl_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             miss_timeout
);
  typedef enum logic {RUN, WAIT} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
  state_t state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_nxt;
  logic hz_exe, hz_mem, hazard, busy, bubble, hold;
  function automatic logic match(input logic [4:0] s, input logic [4:0] d);
    return s == d && d != 5'd0;
  endfunction
  // hazard detection and prioritised freeze/flush; a cache freeze must never see a flush
  always_comb begin
    hz_exe = bus.WB_EN_EXE && (match(bus.Src1_ID, bus.Dst_EXE) || bus.two_src_ID && match(bus.Src2_ID, bus.Dst_EXE));
    hz_mem = bus.WB_EN_MEM && (match(bus.Src1_ID, bus.Dst_MEM) || bus.two_src_ID && match(bus.Src2_ID, bus.Dst_MEM));
    hazard = bus.fwd_en ? hz_exe && bus.MEM_CMD_EXE == 2'b01 : hz_exe || hz_mem;
    busy = bus.MEM_CMD_MEM != 2'b00 && !bus.cache_ready;
    bubble = !busy && !bus.Br_taken && hazard;
    bus.Freeze_pipe = rst && busy;
    bus.Freeze_IF = rst && (busy || bubble);
    bus.Flush_IF = rst && !busy && bus.Br_taken;
    bus.Flush_ID = rst && !busy && (bus.Br_taken || hazard);
  end
  // miss FSM next state; wait_cnt parks at TIMEOUT-1 while the miss persists
  always_comb begin
    state_nxt = state == RUN ? (busy ? WAIT : RUN) : (bus.cache_ready ? RUN : WAIT);
    hold = state == WAIT && !bus.cache_ready;
    wait_nxt = !hold ? '0 : wait_cnt == LIMIT ? wait_cnt : wait_cnt + 1'b1;
  end
  // state, sticky timeout and saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wait_cnt <= '0;
      miss_timeout <= 1'b0;
      stall_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      wait_cnt <= wait_nxt;
      miss_timeout <= miss_timeout || state_nxt == WAIT && wait_nxt == LIMIT;
      stall_cnt <= bubble && !(&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
      miss_cnt <= busy && !(&miss_cnt) ? miss_cnt + 1'b1 : miss_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and random checks against a rule-level reference model
module tb_hazard_stall_ctrl;
  localparam int CNT_W = 4;
  localparam int TIMEOUT = 4;
  localparam int MAXV = 15;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CNT_W-1:0] stall_cnt, miss_cnt;
  logic miss_timeout;
  int tests = 0, fails = 0;
  int m_stall = 0, m_miss = 0, m_run = 0;
  int m_to = 0;
  hazard_stall_ctrl_if bus();
  hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .miss_cnt(miss_cnt), .miss_timeout(miss_timeout)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected {Freeze_IF, Flush_IF, Flush_ID, Freeze_pipe} from the stated rules
  function automatic logic [3:0] exp_ctrl();
    logic [4:0] srcs [2];
    bit haz = 0;
    srcs[0] = bus.Src1_ID;
    srcs[1] = bus.Src2_ID;
    for (int i = 0; i < (bus.two_src_ID ? 2 : 1); i++)
      if (srcs[i] != 0) begin
        if (srcs[i] == bus.Dst_EXE && bus.WB_EN_EXE && (!bus.fwd_en || bus.MEM_CMD_EXE == 2'b01)) haz = 1;
        if (!bus.fwd_en && srcs[i] == bus.Dst_MEM && bus.WB_EN_MEM) haz = 1;
      end
    if (bus.MEM_CMD_MEM != 0 && !bus.cache_ready) return 4'b1001;
    if (bus.Br_taken) return 4'b0110;
    if (haz) return 4'b1010;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] ctrl();
    return {bus.Freeze_IF, bus.Flush_IF, bus.Flush_ID, bus.Freeze_pipe};
  endfunction

  task automatic chk_cnt(input string tag);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), m_stall);
    chk({tag, " miss_cnt"}, 32'(miss_cnt), m_miss);
    chk({tag, " miss_timeout"}, 32'(miss_timeout), m_to);
  endtask

  task automatic cycle(input string tag);
    logic [3:0] e;
    @(negedge clk);
    e = exp_ctrl();
    chk({tag, " ctrl"}, 32'(ctrl()), 32'(e));
    @(posedge clk);
    if (e == 4'b1010) m_stall = m_stall < MAXV ? m_stall + 1 : MAXV;
    if (e[0]) m_miss = m_miss < MAXV ? m_miss + 1 : MAXV;
    m_run = e[0] ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_to = 1;
    #1;
    chk_cnt(tag);
  endtask

  task automatic rst_pulse(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, " ctrl in reset"}, 32'(ctrl()), 0);
    m_stall = 0; m_miss = 0; m_run = 0; m_to = 0;
    chk_cnt(tag);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle();
    bus.fwd_en = 0; bus.Src1_ID = 0; bus.Src2_ID = 0; bus.two_src_ID = 0;
    bus.Dst_EXE = 0; bus.WB_EN_EXE = 0; bus.MEM_CMD_EXE = 0;
    bus.Dst_MEM = 0; bus.WB_EN_MEM = 0; bus.MEM_CMD_MEM = 0;
    bus.cache_ready = 1; bus.Br_taken = 0;
  endtask

  initial begin
    bit stay = 0;
    idle();
    bus.Src1_ID = 5; bus.Dst_EXE = 5; bus.WB_EN_EXE = 1; bus.MEM_CMD_MEM = 1; bus.cache_ready = 0; bus.Br_taken = 1;
    @(posedge clk);
    #1;
    rst_pulse("reset");
    // load/ALU hazard without forwarding
    idle();
    bus.Src1_ID = 5; bus.Dst_EXE = 5; bus.WB_EN_EXE = 1;
    cycle("t1 exe hazard");
    chk("t1 stall one", 32'(stall_cnt), 1);
    bus.Dst_EXE = 7; bus.Dst_MEM = 5; bus.WB_EN_MEM = 1;
    cycle("t1 mem hazard");
    bus.Src1_ID = 9; bus.Src2_ID = 5; bus.two_src_ID = 0;
    cycle("t1 src2 not real");
    bus.two_src_ID = 1;
    cycle("t1 src2 real");
    // forwarding present: only load-use stalls
    idle();
    bus.fwd_en = 1; bus.Src1_ID = 5; bus.Dst_EXE = 5; bus.WB_EN_EXE = 1;
    cycle("t2 fwd no load");
    bus.MEM_CMD_EXE = 2'b01;
    cycle("t2 load use");
    bus.Src1_ID = 0; bus.Dst_EXE = 0;
    cycle("t2 reg zero");
    bus.fwd_en = 0;
    cycle("t2 reg zero nofwd");
    // taken branch overrides hazard
    idle();
    bus.Src1_ID = 5; bus.Dst_EXE = 5; bus.WB_EN_EXE = 1; bus.Br_taken = 1;
    cycle("t3 branch over hazard");
    chk("t3 flush_if", 32'(bus.Flush_IF), 1);
    // cache miss of three cycles with a branch pending
    idle();
    bus.Br_taken = 1; bus.MEM_CMD_MEM = 2'b01; bus.cache_ready = 0;
    for (int i = 0; i < 3; i++) cycle("t4 miss");
    bus.cache_ready = 1;
    cycle("t4 ready");
    chk("t4 miss_cnt three", 32'(miss_cnt), 3);
    // timeout and sticky flag
    idle();
    bus.MEM_CMD_MEM = 2'b10; bus.cache_ready = 0;
    for (int i = 0; i < 6; i++) cycle("t5 long miss");
    chk("t5 timeout set", 32'(miss_timeout), 1);
    bus.cache_ready = 1;
    cycle("t5 ready");
    cycle("t5 sticky");
    bus.cache_ready = 0;
    cycle("t5 new miss");
    cycle("t5 in wait");
    rst_pulse("t5 reset mid wait");
    for (int i = 0; i < 3; i++) cycle("t5 after reset");
    chk("t5 timeout clear", 32'(miss_timeout), 0);
    bus.cache_ready = 1;
    cycle("t5 end");
    // counter saturation
    idle();
    bus.Src1_ID = 3; bus.Dst_MEM = 3; bus.WB_EN_MEM = 1;
    for (int i = 0; i < 20; i++) cycle("t6 stall sat");
    chk("t6 stall at max", 32'(stall_cnt), MAXV);
    bus.MEM_CMD_MEM = 2'b01; bus.cache_ready = 0;
    for (int i = 0; i < 20; i++) cycle("t6 miss sat");
    chk("t6 miss at max", 32'(miss_cnt), MAXV);
    // randomized traffic; idle memory always reports ready
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 59) rst_pulse("rand reset");
      bus.fwd_en = 1'($urandom_range(0, 1));
      bus.Src1_ID = 5'($urandom_range(0, 3));
      bus.Src2_ID = 5'($urandom_range(0, 3));
      bus.two_src_ID = 1'($urandom_range(0, 1));
      bus.Dst_EXE = 5'($urandom_range(0, 3));
      bus.WB_EN_EXE = 1'($urandom_range(0, 1));
      bus.MEM_CMD_EXE = 2'($urandom_range(0, 2));
      bus.Dst_MEM = 5'($urandom_range(0, 3));
      bus.WB_EN_MEM = 1'($urandom_range(0, 1));
      bus.Br_taken = $urandom_range(0, 4) == 0;
      if (stay) stay = $urandom_range(0, 5) != 0;
      else begin
        bus.MEM_CMD_MEM = 2'($urandom_range(0, 2));
        stay = bus.MEM_CMD_MEM != 0 && $urandom_range(0, 2) == 0;
      end
      bus.cache_ready = !stay;
      cycle("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
